lfsr_bist_engine: RTL

//  Parametrised LFSR engine for on-chip BIST. It succeeds the fixed 4-bit LFSR with generic width and tap mask,

---
 rtl/lfsr_bist_pkg.sv | 18 +
 rtl/lfsr_step.sv | 22 ++
 rtl/lfsr_bist_engine.sv | 109 ++++++++++
 3 files changed

// File: rtl/lfsr_bist_pkg.sv
// Shared types and constants for the LFSR BIST engine: FSM states, mode encodings
// and recommended maximal-length feedback masks for common widths.
package lfsr_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_PRPG = 1'b0;
    localparam logic MODE_MISR = 1'b1;

    localparam logic [3:0]  TAPS_4  = 4'b1100;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state of a Fibonacci LFSR shifting toward the MSB;
// in MISR mode the shifted value is XOR-compacted with the incoming data word.
module lfsr_step
    import lfsr_bist_pkg::*;
#(
    parameter int              NBIT = 8,
    parameter logic [NBIT-1:0] TAPS = TAPS_8
) (
    input  logic [NBIT-1:0] q,
    input  logic [NBIT-1:0] din,
    input  logic            mode,
    output logic [NBIT-1:0] q_next
);

    logic            fb;
    logic [NBIT-1:0] shifted;

    assign fb      = ^(q & TAPS);
    assign shifted = {q[NBIT-2:0], fb};
    assign q_next  = (mode == MODE_MISR) ? (shifted ^ din) : shifted;

endmodule

// File: rtl/lfsr_bist_engine.sv
// BIST LFSR engine: runs a bounded number of PRPG or MISR steps per start,
// with runtime seed load and all-zero lockup recovery in PRPG mode.
module lfsr_bist_engine
    import lfsr_bist_pkg::*;
#(
    parameter int              NBIT  = 8,
    parameter logic [NBIT-1:0] TAPS  = TAPS_8,
    parameter logic [NBIT-1:0] SEED  = '1,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] npat,
    input  logic             seed_ld,
    input  logic [NBIT-1:0]  seed_in,
    input  logic [NBIT-1:0]  din,
    output logic [NBIT-1:0]  q,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] npat_r;
    logic             mode_r;
    logic [NBIT-1:0]  q_step;
    logic             last_step;

    lfsr_step #(
        .NBIT (NBIT),
        .TAPS (TAPS)
    ) u_step (
        .q      (q),
        .din    (din),
        .mode   (mode_r),
        .q_next (q_step)
    );

    assign last_step = (count == npat_r - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nxt = (npat != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= SEED;
            count  <= '0;
            npat_r <= '0;
            mode_r <= MODE_PRPG;
            lockup <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Seed load and start may coincide: the first step then uses the new seed.
                    if (seed_ld) begin
                        q <= seed_in;
                    end
                    if (start && (npat != '0)) begin
                        count  <= '0;
                        npat_r <= npat;
                        mode_r <= mode;
                        lockup <= 1'b0;
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    // An all-zero PRPG register would stick forever, so restart from SEED.
                    if ((mode_r == MODE_PRPG) && (q == '0)) begin
                        q      <= SEED;
                        lockup <= 1'b1;
                    end else begin
                        q <= q_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
